// File: rtl/jt49_cmd_player.sv
// Replays a stored command stream onto jt49_bus chips via bdir/bc1/din strobes.
// Define JT49_PLAYER_LOOP_EN to allow restarting the stream while loop=1.
module jt49_cmd_player #(
  parameter int AW         = 12,
  parameter int CSW        = 0,
  parameter int GAP        = 8,
  parameter int WAIT_SHIFT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                loop,
  output logic [AW-1:0]       rom_addr,
  input  logic [10+CSW-1:0]   rom_data,
  output logic [2**CSW-1:0]   bdir,
  output logic                bc1,
  output logic [7:0]          din,
  output logic                busy,
  output logic                done,
  output logic                looped
);

  localparam int NCH = 1 << CSW;
  localparam int CHW = (CSW > 0) ? CSW : 1;
  localparam int WCW = 8 + WAIT_SHIFT;
  localparam int GCW = $clog2(GAP + 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_STROBE, S_GAP, S_WAIT} state_t;

  state_t           state, state_nx;
  logic [AW-1:0]    rom_addr_nx;
  logic [NCH-1:0]   bdir_nx;
  logic             bc1_nx, done_nx, looped_nx;
  logic [7:0]       din_nx;
  logic [CHW-1:0]   chip, chip_nx, cmd_chip;
  logic [WCW-1:0]   wcnt, wcnt_nx;
  logic [GCW-1:0]   gcnt, gcnt_nx;
  logic             adv, fin;

  generate
    if (CSW > 0) begin : g_cs
      assign cmd_chip = rom_data[10+CSW-1:10];
    end else begin : g_nocs
      assign cmd_chip = '0;
    end
  endgenerate

`ifndef JT49_PLAYER_LOOP_EN
  logic unused_loop;
  assign unused_loop = loop;
`endif

  always_comb begin
    state_nx    = state;
    rom_addr_nx = rom_addr;
    bdir_nx     = '0;
    bc1_nx      = bc1;
    din_nx      = din;
    done_nx     = 1'b0;
    looped_nx   = 1'b0;
    wcnt_nx     = wcnt;
    gcnt_nx     = gcnt;
    chip_nx     = chip;
    adv         = 1'b0;
    fin         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          rom_addr_nx = '0;
          state_nx    = S_FETCH;
        end
      end
      S_FETCH: state_nx = S_DECODE;
      S_DECODE: begin
        case (rom_data[9:8])
          2'b11: fin = 1'b1;
          2'b10: begin
            if (rom_data[7:0] != 8'd0) begin
              wcnt_nx  = WCW'(rom_data[7:0]) << WAIT_SHIFT;
              state_nx = S_WAIT;
            end else begin
              adv = 1'b1;
            end
          end
          default: begin
            bc1_nx   = rom_data[8];
            din_nx   = rom_data[7:0];
            chip_nx  = cmd_chip;
            state_nx = S_STROBE;
          end
        endcase
      end
      // bdir is registered, so it is high during the first GAP clock while bc1 is still valid
      S_STROBE: begin
        bdir_nx  = NCH'(1) << chip;
        gcnt_nx  = GCW'(GAP - 1);
        state_nx = S_GAP;
      end
      S_GAP: begin
        bc1_nx = 1'b0;
        if (gcnt == '0) adv = 1'b1;
        else            gcnt_nx = gcnt - GCW'(1);
      end
      S_WAIT: begin
        wcnt_nx = wcnt - WCW'(1);
        if (wcnt == WCW'(1)) adv = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase

    if (adv) begin
      if (rom_addr == '1) begin
        fin = 1'b1;
      end else begin
        rom_addr_nx = rom_addr + AW'(1);
        state_nx    = S_FETCH;
      end
    end

    if (fin) begin
`ifdef JT49_PLAYER_LOOP_EN
      if (loop) begin
        rom_addr_nx = '0;
        looped_nx   = 1'b1;
        state_nx    = S_FETCH;
      end else begin
        done_nx  = 1'b1;
        state_nx = S_IDLE;
      end
`else
      done_nx  = 1'b1;
      state_nx = S_IDLE;
`endif
    end

    if (abort) begin
      state_nx    = S_IDLE;
      rom_addr_nx = rom_addr;
      bdir_nx     = '0;
      bc1_nx      = 1'b0;
      din_nx      = din;
      wcnt_nx     = '0;
      gcnt_nx     = '0;
      done_nx     = 1'b0;
      looped_nx   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      bdir     <= '0;
      bc1      <= 1'b0;
      din      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      looped   <= 1'b0;
      chip     <= '0;
      wcnt     <= '0;
      gcnt     <= '0;
    end else begin
      state    <= state_nx;
      rom_addr <= rom_addr_nx;
      bdir     <= bdir_nx;
      bc1      <= bc1_nx;
      din      <= din_nx;
      busy     <= (state_nx != S_IDLE);
      done     <= done_nx;
      looped   <= looped_nx;
      chip     <= chip_nx;
      wcnt     <= wcnt_nx;
      gcnt     <= gcnt_nx;
    end
  end

endmodule

// File: tb/tb_jt49_cmd_player.sv
// Randomized bench for jt49_cmd_player against a command-level expected-trace model,
// plus directed runs with hand-computed cycle positions.
module tb_jt49_cmd_player;
  localparam int AW    = 4;
  localparam int CSW   = 2;
  localparam int GAP   = 3;
  localparam int WS    = 2;
  localparam int NCH   = 1 << CSW;
  localparam int DW    = 10 + CSW;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n, start, abort, loop;
  logic [AW-1:0]   rom_addr;
  logic [DW-1:0]   rom_data;
  logic [NCH-1:0]  bdir;
  logic            bc1, busy, done, looped;
  logic [7:0]      din;
  logic [DW-1:0]   rom [DEPTH];

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  jt49_cmd_player #(.AW(AW), .CSW(CSW), .GAP(GAP), .WAIT_SHIFT(WS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .loop(loop),
    .rom_addr(rom_addr), .rom_data(rom_data), .bdir(bdir), .bc1(bc1),
    .din(din), .busy(busy), .done(done), .looped(looped)
  );

  typedef struct packed {
    logic [AW-1:0]  addr;
    logic [NCH-1:0] bdir;
    logic           bc1;
    logic [7:0]     din;
    logic           busy;
    logic           done;
    logic           looped;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  bit   active;
  int   checks = 0;
  int   errors = 0;

  function automatic rec_t mk(input int a, input logic [NCH-1:0] b, input logic c1,
                              input logic [7:0] d, input logic lp);
    rec_t r;
    r.addr = AW'(a); r.bdir = b; r.bc1 = c1; r.din = d;
    r.busy = 1'b1; r.done = 1'b0; r.looped = lp;
    return r;
  endfunction

  // Expected outputs for one pass over the stream, one record per clock.
  function automatic void gen_pass(input bit lp);
    logic [7:0]    d = cur.din;
    logic [DW-1:0] c;
    int a = 0;
    int w;
    bit fin = 0;
    bit first = 1;
    while (!fin) begin
      c = rom[a];
      q.push_back(mk(a, '0, 1'b0, d, lp && first));
      first = 0;
      q.push_back(mk(a, '0, 1'b0, d, 1'b0));
      if (c[9:8] == 2'b11) begin
        fin = 1;
      end else begin
        if (c[9]) begin
          w = int'(c[7:0]) * (1 << WS);
          repeat (w) q.push_back(mk(a, '0, 1'b0, d, 1'b0));
        end else begin
          d = c[7:0];
          q.push_back(mk(a, '0, c[8], d, 1'b0));
          q.push_back(mk(a, NCH'(1) << c[DW-1:10], c[8], d, 1'b0));
          repeat (GAP - 1) q.push_back(mk(a, '0, 1'b0, d, 1'b0));
        end
        if (a == DEPTH - 1) fin = 1;
        else a++;
      end
    end
  endfunction

  function automatic void model_step();
    if (!rst_n) begin
      q.delete(); active = 0; cur = '0;
    end else if (abort) begin
      q.delete(); active = 0;
      cur.bdir = '0; cur.bc1 = 1'b0; cur.busy = 1'b0; cur.done = 1'b0; cur.looped = 1'b0;
    end else if (!active) begin
      cur.done = 1'b0; cur.looped = 1'b0;
      if (start) begin
        active = 1; gen_pass(1'b0); cur = q.pop_front();
      end
    end else if (q.size() > 0) begin
      cur = q.pop_front();
    end else begin
`ifdef JT49_PLAYER_LOOP_EN
      if (loop) begin
        gen_pass(1'b1); cur = q.pop_front();
      end else begin
        active = 0; cur.busy = 1'b0; cur.done = 1'b1; cur.bdir = '0; cur.bc1 = 1'b0; cur.looped = 1'b0;
      end
`else
      active = 0; cur.busy = 1'b0; cur.done = 1'b1; cur.bdir = '0; cur.bc1 = 1'b0; cur.looped = 1'b0;
`endif
    end
  endfunction

  task automatic tick();
    rec_t act;
    @(negedge clk);
    model_step();
    act.addr = rom_addr; act.bdir = bdir; act.bc1 = bc1; act.din = din;
    act.busy = busy; act.done = done; act.looped = looped;
    checks++;
    if (act !== cur) begin
      errors++;
      $display("FAIL outputs t=%0t got addr=%0d bdir=%b bc1=%b din=%h busy=%b done=%b looped=%b want addr=%0d bdir=%b bc1=%b din=%h busy=%b done=%b looped=%b",
               $time, act.addr, act.bdir, act.bc1, act.din, act.busy, act.done, act.looped,
               cur.addr, cur.bdir, cur.bc1, cur.din, cur.busy, cur.done, cur.looped);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  int         pulse_cyc[$];
  int         pulse_val[$];
  int         pulse_din[$];
  int         pulse_bc1[$];
  int         done_cyc;
  logic [AW-1:0] done_addr;

  task automatic run_start(input int maxc);
    pulse_cyc.delete(); pulse_val.delete(); pulse_din.delete(); pulse_bc1.delete();
    done_cyc = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < maxc; n++) begin
      if (n > 0) tick();
      if (bdir != '0) begin
        pulse_cyc.push_back(n); pulse_val.push_back(int'(bdir));
        pulse_din.push_back(int'(din)); pulse_bc1.push_back(int'(bc1));
      end
      if (done) begin
        done_cyc = n; done_addr = rom_addr;
        break;
      end
    end
  endtask

  function automatic int qget(input int qq[$], input int i);
    return (qq.size() > i) ? qq[i] : -1;
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 12'h300;
  endtask

  task automatic load_basic();
    clear_rom();
    rom[0] = 12'hC07; rom[1] = 12'h13F; rom[2] = 12'h300;
  endtask

  initial begin
    int n;
    bit any_done;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop = 1'b0;
    active = 0; cur = '0;
    clear_rom();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Two writes then stop: strobes at cycles 3 and 3+(3+GAP), done at 14
    load_basic();
    run_start(60);
    chk("t1_pulses", pulse_cyc.size(), 2);
    chk("t1_p0_cyc", qget(pulse_cyc, 0), 3);
    chk("t1_p0_bdir", qget(pulse_val, 0), 8);
    chk("t1_p0_din", qget(pulse_din, 0), 'h07);
    chk("t1_p0_bc1", qget(pulse_bc1, 0), 0);
    chk("t1_p1_cyc", qget(pulse_cyc, 1), 9);
    chk("t1_p1_bdir", qget(pulse_val, 1), 1);
    chk("t1_p1_din", qget(pulse_din, 1), 'h3F);
    chk("t1_p1_bc1", qget(pulse_bc1, 1), 1);
    chk("t1_done_cyc", done_cyc, 14);
    chk("t1_busy_at_done", int'(busy), 0);
    repeat (3) tick();

    // Wait 2<<WS = 8 clocks: done at 2+8+2
    clear_rom();
    rom[0] = 12'h202;
    run_start(60);
    chk("t2_pulses", pulse_cyc.size(), 0);
    chk("t2_done_cyc", done_cyc, 12);
    repeat (3) tick();

    // Full store of writes, no stop: end after last GAP, address held at top
    for (int i = 0; i < DEPTH; i++) rom[i] = {2'(i), 2'b00, 8'(i * 17)};
    run_start(200);
    chk("t3_pulses", pulse_cyc.size(), DEPTH);
    chk("t3_done_cyc", done_cyc, DEPTH * (3 + GAP));
    chk("t3_done_addr", int'(done_addr), DEPTH - 1);
    chk("t3_last_bdir", qget(pulse_val, DEPTH - 1), 1 << ((DEPTH - 1) % 4));
    repeat (3) tick();

    // Abort during a long wait, then replay from address 0
    clear_rom();
    rom[0] = 12'h2FF;
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_busy_after_abort", int'(busy), 0);
    any_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || bdir != '0) any_done = 1;
    end
    chk("t4_quiet_after_abort", int'(any_done), 0);
    load_basic();
    run_start(60);
    chk("t4_replay_p0", qget(pulse_cyc, 0), 3);
    chk("t4_replay_done", done_cyc, 14);
    repeat (2) tick();

    // Asynchronous reset while bdir is high
    load_basic();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (bdir == '0 && n < 20) begin tick(); n++; end
    chk("t5_strobe_seen", int'(bdir != '0), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_bdir", int'(bdir), 0);
    chk("t5_async_busy", int'(busy), 0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Randomized streams with stray starts, aborts and loop toggling
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        int k;
        k = $urandom_range(0, 9);
        if (k < 7)      rom[i] = {2'($urandom), 1'b0, 1'($urandom), 8'($urandom)};
        else if (k < 9) rom[i] = {2'($urandom), 2'b10, 8'($urandom_range(0, 6))};
        else            rom[i] = {2'($urandom), 2'b11, 8'($urandom)};
      end
      loop = 1'($urandom);
      start = 1'b1; tick(); start = 1'b0;
      n = 0;
      while (n < 3000 && (busy || cur.busy)) begin
        start = ($urandom_range(0, 15) == 0);
        abort = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 63) == 0) loop = ~loop;
        if (n > 1500) loop = 1'b0;
        tick();
        n++;
      end
      start = 1'b0; abort = 1'b0;
      chk("rand_terminated", int'(n < 3000), 1);
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
